tile_pixel_shifter: RTL

- Consumer end of the tilemap fetch interface.
- The tilemap address generator drives graphics ROM addresses and per-layer commit strobes (HA2 for layer A, HB2 for layer B). This block captures the ROM byte and tile attribute on each strobe, double-buffers them, and serialises one 2bpp pen per layer per CLK_6M.
- Its output feeds the layer priority/colour mixer.
- Two identical layer channels share one clock and reset.

---
 rtl/tile_pixel_shifter_if.sv | 28 ++
 rtl/tile_pixel_shifter.sv | 114 +++++++++++
 2 files changed

// File: rtl/tile_pixel_shifter_if.sv
// Fetch-side load strobes and data plus the per-layer pixel outputs toward the mixer.
// The address generator (master) drives the loads; the shifter (slave) returns pixels and status.
interface tile_pixel_shifter_if #(
    parameter int ATTR_W = 8
);
    logic              HA2;
    logic              HB2;
    logic [7:0]        GD;
    logic [ATTR_W-1:0] ATTR;
    logic              FLIP;
    logic              CLR_FLAGS;
    logic [ATTR_W+1:0] PIX_A;
    logic [ATTR_W+1:0] PIX_B;
    logic              OPAQUE_A;
    logic              OPAQUE_B;
    logic [1:0]        OVERRUN;
    logic [1:0]        UNDERRUN;

    modport master (
        output HA2, HB2, GD, ATTR, FLIP, CLR_FLAGS,
        input  PIX_A, PIX_B, OPAQUE_A, OPAQUE_B, OVERRUN, UNDERRUN
    );

    modport slave (
        input  HA2, HB2, GD, ATTR, FLIP, CLR_FLAGS,
        output PIX_A, PIX_B, OPAQUE_A, OPAQUE_B, OVERRUN, UNDERRUN
    );
endinterface

// File: rtl/tile_pixel_shifter.sv
// Two-layer tile pixel shifter: each layer double-buffers a ROM byte and attribute
// and serialises one 2bpp pen per CLK_6M, with sticky overrun/underrun status.
module tile_pixel_shifter #(
    parameter int         ATTR_W          = 8,
    parameter logic [1:0] TRANSPARENT_PEN = 2'b00
) (
    input  logic                  CLK_6M,
    input  logic                  RESET,
    tile_pixel_shifter_if.slave   bus
);
    // Index 0 is layer A, index 1 is layer B throughout.
    logic [1:0]                   w_load;
    logic [1:0]                   w_consume;
    logic [1:0]                   w_set_ovr;
    logic [1:0]                   w_set_und;
    logic [1:0][1:0]              w_first_pen;
    logic [1:0][5:0]              w_rest;
    logic [1:0][1:0]              w_emit_pen;
    logic [1:0][ATTR_W-1:0]       w_emit_attr;

    logic [1:0][7:0]              r_hold_pens;
    logic [1:0][ATTR_W-1:0]       r_hold_attr;
    logic [1:0]                   r_hold_flip;
    logic [1:0]                   r_hold_valid;
    logic [1:0]                   r_armed;
    logic [1:0][5:0]              r_shift;
    logic [1:0][ATTR_W-1:0]       r_shift_attr;
    logic [1:0][1:0]              r_count;
    logic [1:0][ATTR_W+1:0]       r_pix;
    logic [1:0]                   r_opaque;
    logic [1:0]                   r_overrun;
    logic [1:0]                   r_underrun;

    assign w_load = {bus.HB2, bus.HA2};

    always_comb begin
        w_consume   = '0;
        w_set_ovr   = '0;
        w_set_und   = '0;
        w_first_pen = '0;
        w_rest      = '0;
        w_emit_pen  = '0;
        w_emit_attr = '0;
        for (int unsigned l = 0; l < 2; l++) begin
            // The shifter holds the remaining pens in emission order, next pen in [1:0].
            w_first_pen[l] = r_hold_flip[l] ? r_hold_pens[l][7:6] : r_hold_pens[l][1:0];
            w_rest[l]      = r_hold_flip[l]
                           ? {r_hold_pens[l][1:0], r_hold_pens[l][3:2], r_hold_pens[l][5:4]}
                           : r_hold_pens[l][7:2];
            w_consume[l]   = (r_count[l] == 2'd0) && r_hold_valid[l];
            if (r_count[l] != 2'd0) begin
                w_emit_pen[l]  = r_shift[l][1:0];
                w_emit_attr[l] = r_shift_attr[l];
            end else if (r_hold_valid[l]) begin
                w_emit_pen[l]  = w_first_pen[l];
                w_emit_attr[l] = r_hold_attr[l];
            end else begin
                w_emit_pen[l]  = TRANSPARENT_PEN;
                w_emit_attr[l] = '0;
                w_set_und[l]   = r_armed[l];
            end
            w_set_ovr[l] = w_load[l] && r_hold_valid[l] && !w_consume[l];
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (RESET) begin
            r_hold_pens  <= '0;
            r_hold_attr  <= '0;
            r_hold_flip  <= '0;
            r_hold_valid <= '0;
            r_armed      <= '0;
            r_shift      <= '0;
            r_shift_attr <= '0;
            r_count      <= '0;
            r_opaque     <= '0;
            r_overrun    <= '0;
            r_underrun   <= '0;
            for (int unsigned l = 0; l < 2; l++) begin
                r_pix[l] <= {{ATTR_W{1'b0}}, TRANSPARENT_PEN};
            end
        end else begin
            for (int unsigned l = 0; l < 2; l++) begin
                if (w_load[l]) begin
                    r_hold_pens[l] <= bus.GD;
                    r_hold_attr[l] <= bus.ATTR;
                    r_hold_flip[l] <= bus.FLIP;
                    r_armed[l]     <= 1'b1;
                end
                r_hold_valid[l] <= w_load[l] | (r_hold_valid[l] & ~w_consume[l]);
                if (r_count[l] != 2'd0) begin
                    r_shift[l] <= {2'b00, r_shift[l][5:2]};
                    r_count[l] <= r_count[l] - 2'd1;
                end else if (r_hold_valid[l]) begin
                    r_shift[l]      <= w_rest[l];
                    r_shift_attr[l] <= r_hold_attr[l];
                    r_count[l]      <= 2'd3;
                end
                r_pix[l]    <= {w_emit_attr[l], w_emit_pen[l]};
                r_opaque[l] <= (w_emit_pen[l] != TRANSPARENT_PEN);
            end
            // A new event outranks a coincident clear.
            r_overrun  <= (r_overrun  & ~{2{bus.CLR_FLAGS}}) | w_set_ovr;
            r_underrun <= (r_underrun & ~{2{bus.CLR_FLAGS}}) | w_set_und;
        end
    end

    assign bus.PIX_A    = r_pix[0];
    assign bus.PIX_B    = r_pix[1];
    assign bus.OPAQUE_A = r_opaque[0];
    assign bus.OPAQUE_B = r_opaque[1];
    assign bus.OVERRUN  = r_overrun;
    assign bus.UNDERRUN = r_underrun;
endmodule
